// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM encoding, prefix bytes and frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_FRAME_LEN = 11;
    // start, parity and stop surround the data bits
    localparam int         PS2_DATA_BITS = PS2_FRAME_LEN - 3;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Decoded key-code bus between the PS/2 receiver and the key-command decoder.
interface ps2_kbd_rx_if;

    logic [7:0] scan_code;
    logic       is_break;
    logic       is_ext;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output scan_code, is_break, is_ext, code_valid, frame_err
    );

    modport slave (
        input scan_code, is_break, is_ext, code_valid, frame_err
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Synchronizes the raw PS/2 clock/data pins and flags falling edges of the PS/2 clock.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] dat_sr;
    logic                   clk_prev;

    // Flops reset high so an idle bus never looks like an edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr   <= '1;
            dat_sr   <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
            dat_sr   <= {dat_sr[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign data_s = dat_sr[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: assembles 11-bit frames into scan codes and folds
// the E0/F0 prefixes into is_ext/is_break on the following code.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.master bus
);

    localparam int                TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]        BIT_LAST = 3'(PS2_DATA_BITS - 1);

    ps2_state_t       state, state_nx;
    logic             data_s, fall;
    logic [2:0]       bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       shreg;
    logic             par_bit;
    logic             brk_pend, ext_pend;
    logic             timeout, stop_fall, frame_ok;

    logic [7:0]       code_p1;
    logic             brk_p1, ext_p1, vld_p1, err_p1;

    // Stage p0: pin synchronization and edge detection
    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (data_s),
        .fall     (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // A timeout overrides any edge arriving in the same cycle
    always_comb begin
        state_nx  = state;
        stop_fall = 1'b0;
        timeout   = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);
        frame_ok  = data_s & (^{shreg, par_bit});
        if (timeout) begin
            state_nx = ST_IDLE;
        end else if (fall) begin
            case (state)
                ST_IDLE:   if (!data_s) state_nx = ST_DATA;
                ST_DATA:   if (bit_cnt == BIT_LAST) state_nx = ST_PARITY;
                ST_PARITY: state_nx = ST_STOP;
                ST_STOP: begin
                    stop_fall = 1'b1;
                    state_nx  = ST_IDLE;
                end
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fall && !timeout) begin
            if (state == ST_DATA)   shreg   <= {data_s, shreg[7:1]};
            if (state == ST_PARITY) par_bit <= data_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == ST_IDLE || fall || timeout) tmo_cnt <= '0;
            else                                     tmo_cnt <= tmo_cnt + 1'b1;
            if (fall && !timeout) begin
                if (state == ST_IDLE && !data_s) bit_cnt <= '0;
                else if (state == ST_DATA)       bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Stage p1: frame outcome and prefix folding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_p1  <= 8'h00;
            brk_p1   <= 1'b0;
            ext_p1   <= 1'b0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            if (timeout || (stop_fall && !frame_ok)) begin
                err_p1   <= 1'b1;
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end else if (stop_fall) begin
                if (shreg == PS2_BREAK) begin
                    brk_pend <= 1'b1;
                end else if (shreg == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else begin
                    vld_p1   <= 1'b1;
                    code_p1  <= shreg;
                    brk_p1   <= brk_pend;
                    ext_p1   <= ext_pend;
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end
            end
        end
    end

    assign bus.scan_code  = code_p1;
    assign bus.is_break   = brk_p1;
    assign bus.is_ext     = ext_p1;
    assign bus.code_valid = vld_p1;
    assign bus.frame_err  = err_p1;

endmodule
